// File: rtl/clarvi_sliced_regfile.sv
// clarvi_sliced_regfile: slice-serial integer register file for the Clarvi bit-sliced datapath.
//
// Reads and writes move one SLICE_W-bit slice per port per cycle. Partial writes gather
// in a staging buffer and commit to storage as a full word. Read outputs are registered
// and see same-cycle writes, the staged word and then storage, in that order.
//
// Build option: define REGFILE_CLEAR_EN to add a post-reset sequencer that zeroes every
// register, one per cycle, while o_busy is high. Without it o_busy is tied low and storage
// contents after reset are undefined (register 0 still reads as zero).
//
// Ports:
//   i_clock              system clock, rising edge
//   i_reset_n            synchronous active-low reset
//   i_rs1_addr/i_rs2_addr read port register indices
//   i_rd_part            slice index shared by both read ports
//   i_rs2_part_override  port 2 reads slice 0 when set
//   i_wr_en/i_wr_addr/i_wr_part/i_wr_data  slice write
//   i_wr_last            commit the staged word at this edge (qualified by i_wr_en)
//   o_busy               clear sequencer running; writes ignored, reads return 0
//   o_rs1_data/o_rs2_data registered read slices
//   o_debug_word         committed value of register DEBUG_REG
module clarvi_sliced_regfile #(
    parameter int XLEN      = 64,
    parameter int SLICE_W   = 8,
    parameter int NREGS     = 32,
    parameter int DEBUG_REG = 28,
    localparam int NSLICES  = XLEN / SLICE_W,
    localparam int AW       = $clog2(NREGS),
    localparam int PW       = $clog2(NSLICES)
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [AW-1:0]      i_rs1_addr,
    input  logic [AW-1:0]      i_rs2_addr,
    input  logic [PW-1:0]      i_rd_part,
    input  logic               i_rs2_part_override,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [PW-1:0]      i_wr_part,
    input  logic [SLICE_W-1:0] i_wr_data,
    input  logic               i_wr_last,
    output logic               o_busy,
    output logic [SLICE_W-1:0] o_rs1_data,
    output logic [SLICE_W-1:0] o_rs2_data,
    output logic [XLEN-1:0]    o_debug_word
);
    logic [XLEN-1:0]    r_mem [NREGS];
    logic [XLEN-1:0]    r_stage_word;
    logic [AW-1:0]      r_stage_addr;
    logic               r_stage_valid;
    logic [XLEN-1:0]    w_base, w_merged;
    logic [SLICE_W-1:0] w_rs1, w_rs2;
    logic               w_run, w_we, w_stage_hit, w_clr_we;
    logic [AW-1:0]      w_clr_idx;

`ifdef REGFILE_CLEAR_EN
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_clr_idx, w_clr_idx_nxt;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        if (r_state == S_CLEAR) begin
            w_clr_idx_nxt = r_clr_idx + 1'b1;
            if (r_clr_idx == AW'(NREGS - 1))
                w_state_nxt = S_RUN;
        end
    end

    assign w_run     = (r_state == S_RUN);
    assign w_clr_we  = !w_run;
    assign w_clr_idx = r_clr_idx;
`else
    assign w_run     = 1'b1;
    assign w_clr_we  = 1'b0;
    assign w_clr_idx = '0;
`endif

    assign o_busy = !w_run;

    // Writes to register 0 are dropped outright so they never disturb an open stage.
    assign w_we        = i_wr_en && w_run && (i_wr_addr != '0);
    assign w_stage_hit = r_stage_valid && (r_stage_addr == i_wr_addr);
    assign w_base      = w_stage_hit ? r_stage_word : r_mem[i_wr_addr];

    always_comb begin
        w_merged = w_base;
        w_merged[i_wr_part*SLICE_W +: SLICE_W] = i_wr_data;
    end

    // A stage left open by a write to another register is flushed in the same edge that
    // may also commit the new word; the two targets always differ.
    always_ff @(posedge i_clock) begin
        if (w_clr_we)
            r_mem[w_clr_idx] <= '0;
        if (w_we && r_stage_valid && !w_stage_hit)
            r_mem[r_stage_addr] <= r_stage_word;
        if (w_we && i_wr_last)
            r_mem[i_wr_addr] <= w_merged;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n)
            r_stage_valid <= 1'b0;
        else if (w_we) begin
            r_stage_valid <= !i_wr_last;
            r_stage_addr  <= i_wr_addr;
            r_stage_word  <= w_merged;
        end
    end

    function automatic logic [SLICE_W-1:0] fwd_slice(input logic [AW-1:0] a, input logic [PW-1:0] p);
        logic [XLEN-1:0] w;
        w = (r_stage_valid && r_stage_addr == a) ? r_stage_word : r_mem[a];
        if (!w_run || a == '0)
            return '0;
        if (i_wr_en && i_wr_addr == a && i_wr_part == p)
            return i_wr_data;
        return w[p*SLICE_W +: SLICE_W];
    endfunction

    always_comb begin
        w_rs1 = fwd_slice(i_rs1_addr, i_rd_part);
        w_rs2 = fwd_slice(i_rs2_addr, i_rs2_part_override ? '0 : i_rd_part);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            o_rs1_data <= '0;
            o_rs2_data <= '0;
        end else begin
            o_rs1_data <= w_rs1;
            o_rs2_data <= w_rs2;
        end
    end

    assign o_debug_word = (DEBUG_REG == 0) ? '0 : r_mem[AW'(DEBUG_REG)];
endmodule

// File: tb/tb_clarvi_sliced_regfile.sv
// tb_clarvi_sliced_regfile: scoreboard bench for clarvi_sliced_regfile against a word-level model.
module tb_clarvi_sliced_regfile;
    localparam int NR  = 32;
    localparam int DBG = 28;
`ifdef REGFILE_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, wr_addr = '0;
    logic [2:0]  rd_part = '0, wr_part = '0;
    logic        ovr = 1'b0, wr_en = 1'b0, wr_last = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        busy;
    logic [7:0]  rs1_data, rs2_data;
    logic [63:0] debug_word;

    always #5 clk = ~clk;

    clarvi_sliced_regfile dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_part(rd_part),
        .i_rs2_part_override(ovr),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_part(wr_part),
        .i_wr_data(wr_data), .i_wr_last(wr_last),
        .o_busy(busy), .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
        .o_debug_word(debug_word)
    );

    typedef struct {
        logic [7:0]  rs1, rs2;
        logic        busy;
        logic [63:0] dbg;
        bit          c1, c2, cd;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_err = 0;

    // Reference model: committed words, per-byte "value is known" masks, open stage, clear countdown.
    logic [63:0] mem [NR];
    logic [7:0]  kn  [NR];
    bit          sv = 1'b0;
    int          sa = 0;
    logic [63:0] sw = '0;
    logic [7:0]  sk = '0;
    int          mclr = 0;

    initial for (int i = 0; i < NR; i++) begin
        mem[i] = '0;
        kn[i]  = '0;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void fwd(input int a, input int p, input bit run, input bit wen, input int wa,
                                input int wp, input logic [7:0] wd, output logic [7:0] v, output bit k);
        k = 1'b1;
        if (!run || a == 0) v = '0;
        else if (wen && wa == a && wp == p) v = wd;
        else if (sv && sa == a) begin
            v = sw[p*8 +: 8];
            k = sk[p];
        end else begin
            v = mem[a][p*8 +: 8];
            k = kn[a][p];
        end
    endfunction

    task automatic step(input bit rn, input bit wen, input bit last, input bit o, input int a1, input int a2,
                        input int rp, input int wa, input int wp, input logic [7:0] wd);
        exp_t e;
        bit   run;
        @(negedge clk);
        rst_n = rn; wr_en = wen; wr_last = last; ovr = o;
        rs1_addr = 5'(a1); rs2_addr = 5'(a2); rd_part = 3'(rp);
        wr_addr = 5'(wa); wr_part = 3'(wp); wr_data = wd;
        if (!rn) begin
            e.rs1 = '0; e.rs2 = '0; e.c1 = 1'b1; e.c2 = 1'b1;
            sv = 1'b0;
            if (CLR) mclr = NR;
        end else begin
            run = (mclr == 0);
            fwd(a1, rp, run, wen, wa, wp, wd, e.rs1, e.c1);
            fwd(a2, o ? 0 : rp, run, wen, wa, wp, wd, e.rs2, e.c2);
            if (run && wen && wa != 0) begin
                if (sv && sa != wa) begin
                    mem[sa] = sw;
                    kn[sa]  = sk;
                end
                if (!(sv && sa == wa)) begin
                    sw = mem[wa];
                    sk = kn[wa];
                end
                sw[wp*8 +: 8] = wd;
                sk[wp] = 1'b1;
                sa = wa;
                if (last) begin
                    mem[wa] = sw;
                    kn[wa]  = sk;
                    sv = 1'b0;
                end else sv = 1'b1;
            end
            if (!run) begin
                mclr--;
                if (mclr == 0) for (int i = 0; i < NR; i++) begin
                    mem[i] = '0;
                    kn[i]  = '1;
                end
            end
        end
        e.busy = (mclr != 0);
        e.dbg  = mem[DBG];
        e.cd   = !e.busy && kn[DBG] == 8'hFF;
        q.push_back(e);
    endtask

    function automatic int rnd_addr();
        case ($urandom_range(0, 6))
            0: return 0;
            1: return 3;
            2: return 5;
            3: return 7;
            4: return 9;
            5: return 28;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1, 0, 0, 1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), int'($urandom_range(0, 7)), 0, 0, 8'h00);
    endtask

    task automatic wr(input int wa, input int wp, input logic [7:0] wd, input bit last, input int a1, input int rp);
        step(1, 1, last, 0, a1, rnd_addr(), rp, wa, wp, wd);
    endtask

    // Monitor: one registered response per driven edge, checked just after that edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("busy", 64'(busy), 64'(e.busy));
            if (e.c1) chk("rs1_data", 64'(rs1_data), 64'(e.rs1));
            if (e.c2) chk("rs2_data", 64'(rs2_data), 64'(e.rs2));
            if (e.cd) chk("debug_word", debug_word, e.dbg);
        end
    end

    initial begin
        logic [63:0] v28;
        v28 = 64'h0123456789ABCDEF;
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        if (CLR) begin
            idle(NR);
            for (int r = 0; r < NR; r++)
                for (int p = 0; p < 8; p++)
                    step(1, 0, 0, 0, r, (r + 16) % NR, p, 0, 0, 8'h00);
        end else begin
            for (int r = 1; r < NR; r++)
                for (int p = 0; p < 8; p++)
                    wr(r, p, 8'($urandom), p == 7, rnd_addr(), int'($urandom_range(0, 7)));
        end
        for (int p = 0; p < 8; p++) wr(5, p, 8'(8'h11 * (p + 1)), p == 7, 5, p);
        for (int p = 0; p < 8; p++) step(1, 0, 0, 1, 5, 5, p, 0, 0, 8'h00);
        for (int p = 0; p < 8; p++) wr(28, p, v28[p*8 +: 8], p == 7, 28, p);
        wr(28, 2, 8'hFF, 1, 28, 2);
        @(posedge clk);
        #1;
        chk("dbg_x28_const", debug_word, 64'h0123456789FFCDEF);
        wr(7, 0, 8'hAA, 0, 7, 0);
        step(1, 0, 0, 0, 7, 9, 0, 0, 0, 8'h00);
        wr(9, 1, 8'hBB, 0, 7, 0);
        step(1, 0, 0, 0, 7, 9, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 9, 7, 1, 0, 0, 8'h00);
        wr(9, 7, 8'h99, 1, 9, 1);
        step(1, 1, 1, 1, 3, 3, 4, 3, 4, 8'h5C);
        step(1, 0, 0, 1, 3, 3, 4, 0, 0, 8'h00);
        wr(0, 0, 8'hFF, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        wr(4, 1, 8'h3C, 1, 4, 1);
        for (int i = 0; i < 1500; i++) begin
            int wa;
            wa = rnd_addr();
            step(1, $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) != 0 ? wa : rnd_addr(), rnd_addr(), int'($urandom_range(0, 7)),
                 wa, int'($urandom_range(0, 7)), 8'($urandom));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        idle(10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        idle(NR + 4);
        for (int i = 0; i < 300; i++) begin
            int wa;
            wa = rnd_addr();
            step(1, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) != 0 ? wa : rnd_addr(), rnd_addr(), int'($urandom_range(0, 7)),
                 wa, int'($urandom_range(0, 7)), 8'($urandom));
        end
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
